// File: rtl/axi_pkg.sv
// Shared definitions for the AXI master arbiter: arbitration states,
// response codes and fixed write-strobe width.
package axi_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_READ,
        ARB_WRITE
    } arb_state_t;

    localparam logic [1:0]  OKAY    = 2'b00;
    localparam int unsigned WSTRB_W = 8;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector: on a tie the master that did not own the
// previous transaction wins; a sole requester always wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt
);

    always_comb begin
        if (req == 2'b11) begin
            gnt = ~last;
        end else begin
            gnt = req[1];
        end
    end

endmodule

// File: rtl/axi_arbiter.sv
// Arbitrates two AXI-lite style masters (m0 = IFU, m1 = LSU) onto one SRAM
// slave; a whole transaction is owned by one master at a time.
module axi_arbiter
    import axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic [ADDR_W-1:0]   m0_araddr,
    input  logic                m0_arvalid,
    output logic                m0_arready,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic [1:0]          m0_rresp,
    output logic                m0_rvalid,
    input  logic                m0_rready,
    input  logic [ADDR_W-1:0]   m0_awaddr,
    input  logic                m0_awvalid,
    output logic                m0_awready,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [WSTRB_W-1:0]  m0_wstrb,
    input  logic                m0_wvalid,
    output logic                m0_wready,
    output logic                m0_bvalid,
    output logic [1:0]          m0_bresp,
    input  logic                m0_bready,
    input  logic [ADDR_W-1:0]   m1_araddr,
    input  logic                m1_arvalid,
    output logic                m1_arready,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic [1:0]          m1_rresp,
    output logic                m1_rvalid,
    input  logic                m1_rready,
    input  logic [ADDR_W-1:0]   m1_awaddr,
    input  logic                m1_awvalid,
    output logic                m1_awready,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [WSTRB_W-1:0]  m1_wstrb,
    input  logic                m1_wvalid,
    output logic                m1_wready,
    output logic                m1_bvalid,
    output logic [1:0]          m1_bresp,
    input  logic                m1_bready,
    output logic [ADDR_W-1:0]   s_araddr,
    output logic                s_arvalid,
    input  logic                s_arready,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic [1:0]          s_rresp,
    input  logic                s_rvalid,
    output logic                s_rready,
    output logic [ADDR_W-1:0]   s_awaddr,
    output logic                s_awvalid,
    input  logic                s_awready,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [WSTRB_W-1:0]  s_wstrb,
    output logic                s_wvalid,
    input  logic                s_wready,
    input  logic                s_bvalid,
    input  logic [1:0]          s_bresp,
    output logic                s_bready,
    output logic                grant
);

    arb_state_t state, state_nxt;
    logic       grant_nxt, last, last_nxt, win;
    logic       ar_done, ar_done_nxt, aw_done, aw_done_nxt, w_done, w_done_nxt;
    logic [1:0] req;

    logic [ADDR_W-1:0]  own_araddr, own_awaddr;
    logic [DATA_W-1:0]  own_wdata;
    logic [WSTRB_W-1:0] own_wstrb;
    logic               own_arvalid, own_awvalid, own_wvalid, own_rready, own_bready;
    logic               win_arvalid;

    logic               ar_rdy, aw_rdy, w_rdy, r_vld, b_vld;
    logic [DATA_W-1:0]  r_data;
    logic [1:0]         r_resp, b_resp;

    assign req[0] = m0_arvalid | m0_awvalid | m0_wvalid;
    assign req[1] = m1_arvalid | m1_awvalid | m1_wvalid;

    rr_arb2 u_rr_arb2 (
        .req  (req),
        .last (last),
        .gnt  (win)
    );

    assign win_arvalid = win ? m1_arvalid : m0_arvalid;

    assign own_araddr  = grant ? m1_araddr  : m0_araddr;
    assign own_arvalid = grant ? m1_arvalid : m0_arvalid;
    assign own_rready  = grant ? m1_rready  : m0_rready;
    assign own_awaddr  = grant ? m1_awaddr  : m0_awaddr;
    assign own_awvalid = grant ? m1_awvalid : m0_awvalid;
    assign own_wdata   = grant ? m1_wdata   : m0_wdata;
    assign own_wstrb   = grant ? m1_wstrb   : m0_wstrb;
    assign own_wvalid  = grant ? m1_wvalid  : m0_wvalid;
    assign own_bready  = grant ? m1_bready  : m0_bready;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state   <= ARB_IDLE;
            grant   <= 1'b0;
            last    <= 1'b1;
            ar_done <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            last    <= last_nxt;
            ar_done <= ar_done_nxt;
            aw_done <= aw_done_nxt;
            w_done  <= w_done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        last_nxt    = last;
        ar_done_nxt = ar_done;
        aw_done_nxt = aw_done;
        w_done_nxt  = w_done;
        case (state)
            ARB_IDLE: begin
                ar_done_nxt = 1'b0;
                aw_done_nxt = 1'b0;
                w_done_nxt  = 1'b0;
                if (req != 2'b00) begin
                    grant_nxt = win;
                    state_nxt = win_arvalid ? ARB_READ : ARB_WRITE;
                end
            end
            ARB_READ: begin
                if (s_arvalid && s_arready) ar_done_nxt = 1'b1;
                if (s_rvalid && s_rready) begin
                    state_nxt   = ARB_IDLE;
                    last_nxt    = grant;
                    ar_done_nxt = 1'b0;
                end
            end
            ARB_WRITE: begin
                if (s_awvalid && s_awready) aw_done_nxt = 1'b1;
                if (s_wvalid && s_wready)   w_done_nxt  = 1'b1;
                if (s_bvalid && s_bready) begin
                    state_nxt   = ARB_IDLE;
                    last_nxt    = grant;
                    aw_done_nxt = 1'b0;
                    w_done_nxt  = 1'b0;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // Slave-side forwarding; done flags suppress a second handshake per transaction.
    always_comb begin
        s_araddr  = '0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        s_awaddr  = '0;
        s_awvalid = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        ar_rdy    = 1'b0;
        aw_rdy    = 1'b0;
        w_rdy     = 1'b0;
        r_vld     = 1'b0;
        b_vld     = 1'b0;
        r_data    = '0;
        r_resp    = OKAY;
        b_resp    = OKAY;
        case (state)
            ARB_READ: begin
                s_araddr  = own_araddr;
                s_arvalid = own_arvalid & ~ar_done;
                ar_rdy    = s_arready & ~ar_done;
                s_rready  = own_rready;
                r_vld     = s_rvalid;
                r_data    = s_rdata;
                r_resp    = s_rresp;
            end
            ARB_WRITE: begin
                s_awaddr  = own_awaddr;
                s_awvalid = own_awvalid & ~aw_done;
                aw_rdy    = s_awready & ~aw_done;
                s_wdata   = own_wdata;
                s_wstrb   = own_wstrb;
                s_wvalid  = own_wvalid & ~w_done;
                w_rdy     = s_wready & ~w_done;
                s_bready  = own_bready;
                b_vld     = s_bvalid;
                b_resp    = s_bresp;
            end
            default: ;
        endcase
    end

    assign m0_arready = ar_rdy & ~grant;
    assign m0_rvalid  = r_vld  & ~grant;
    assign m0_rdata   = grant ? '0   : r_data;
    assign m0_rresp   = grant ? OKAY : r_resp;
    assign m0_awready = aw_rdy & ~grant;
    assign m0_wready  = w_rdy  & ~grant;
    assign m0_bvalid  = b_vld  & ~grant;
    assign m0_bresp   = grant ? OKAY : b_resp;

    assign m1_arready = ar_rdy & grant;
    assign m1_rvalid  = r_vld  & grant;
    assign m1_rdata   = grant ? r_data : '0;
    assign m1_rresp   = grant ? r_resp : OKAY;
    assign m1_awready = aw_rdy & grant;
    assign m1_wready  = w_rdy  & grant;
    assign m1_bvalid  = b_vld  & grant;
    assign m1_bresp   = grant ? b_resp : OKAY;

endmodule

// File: tb/tb_axi_arbiter.sv
// Directed bench for axi_arbiter with a small SRAM slave responder model.
module tb_axi_arbiter;

    logic        aclk, areset;
    logic [31:0] m0_araddr, m1_araddr, m0_awaddr, m1_awaddr, m0_wdata, m1_wdata;
    logic [7:0]  m0_wstrb, m1_wstrb;
    logic        m0_arvalid, m0_rready, m0_awvalid, m0_wvalid, m0_bready;
    logic        m1_arvalid, m1_rready, m1_awvalid, m1_wvalid, m1_bready;
    logic        m0_arready, m0_rvalid, m0_awready, m0_wready, m0_bvalid;
    logic        m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [1:0]  m0_rresp, m1_rresp, m0_bresp, m1_bresp;
    logic [31:0] s_araddr, s_awaddr, s_wdata, s_rdata;
    logic [7:0]  s_wstrb;
    logic        s_arvalid, s_arready, s_rvalid, s_rready, s_awvalid, s_awready;
    logic        s_wvalid, s_wready, s_bvalid, s_bready;
    logic [1:0]  s_rresp, s_bresp;
    logic        grant;

    axi_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .aclk(aclk), .areset(areset),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m0_awaddr(m0_awaddr), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
        .m0_bvalid(m0_bvalid), .m0_bresp(m0_bresp), .m0_bready(m0_bready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
        .m1_bvalid(m1_bvalid), .m1_bresp(m1_bresp), .m1_bready(m1_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
        .grant(grant)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Slave responder: one outstanding read, B issued once both AW and W arrived.
    logic        slv_rv, slv_awg, slv_wg, slv_bv;
    logic [31:0] slv_rdata_val, cap_wdata, cap_awaddr;
    logic [1:0]  slv_rresp_val, slv_bresp_val;
    logic [7:0]  cap_wstrb;
    int          n_ar = 0, n_aw = 0, n_w = 0;

    assign s_arready = !slv_rv;
    assign s_rvalid  = slv_rv;
    assign s_awready = !slv_awg;
    assign s_wready  = !slv_wg;
    assign s_bvalid  = slv_bv;

    always @(posedge aclk) begin
        if (areset) begin
            slv_rv  <= 1'b0;
            slv_awg <= 1'b0;
            slv_wg  <= 1'b0;
            slv_bv  <= 1'b0;
            s_rdata <= '0;
            s_rresp <= '0;
            s_bresp <= '0;
        end else begin
            if (s_arvalid && s_arready) begin
                slv_rv  <= 1'b1;
                s_rdata <= slv_rdata_val;
                s_rresp <= slv_rresp_val;
                n_ar    <= n_ar + 1;
            end
            if (s_rvalid && s_rready) slv_rv <= 1'b0;
            if (s_awvalid && s_awready) begin
                slv_awg    <= 1'b1;
                cap_awaddr <= s_awaddr;
                n_aw       <= n_aw + 1;
            end
            if (s_wvalid && s_wready) begin
                slv_wg    <= 1'b1;
                cap_wdata <= s_wdata;
                cap_wstrb <= s_wstrb;
                n_w       <= n_w + 1;
            end
            if (slv_awg && slv_wg && !slv_bv) begin
                slv_bv  <= 1'b1;
                s_bresp <= slv_bresp_val;
            end
            if (s_bvalid && s_bready) begin
                slv_bv  <= 1'b0;
                slv_awg <= 1'b0;
                slv_wg  <= 1'b0;
            end
        end
    end

    int          checks = 0, failures = 0, both_active = 0;
    int          done_q[$];
    logic [31:0] rcap_data [2];
    logic [1:0]  rcap_resp [2];
    logic [1:0]  bcap_resp [2];
    int          s_ar0, s_aw0, s_w0;
    logic [40:0] m0_outs, m1_outs;

    assign m0_outs = {m0_arready, m0_rvalid, m0_awready, m0_wready, m0_bvalid, m0_rdata, m0_rresp, m0_bresp};
    assign m1_outs = {m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid, m1_rdata, m1_rresp, m1_bresp};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int qget(input int i);
        if (i < done_q.size()) return done_q[i];
        return 99;
    endfunction

    // One clock: sample handshakes before the edge, retire handshaken valids after it.
    // Completion codes: 0/1 = R to m0/m1, 2/3 = B to m0/m1.
    task automatic tick();
        logic h0ar, h1ar, h0aw, h1aw, h0w, h1w, h0r, h1r, h0b, h1b;
        logic [31:0] d0, d1;
        logic [1:0]  rr0, rr1, br0, br1;
        @(negedge aclk);
        h0ar = m0_arvalid && m0_arready;  h1ar = m1_arvalid && m1_arready;
        h0aw = m0_awvalid && m0_awready;  h1aw = m1_awvalid && m1_awready;
        h0w  = m0_wvalid  && m0_wready;   h1w  = m1_wvalid  && m1_wready;
        h0r  = m0_rvalid  && m0_rready;   h1r  = m1_rvalid  && m1_rready;
        h0b  = m0_bvalid  && m0_bready;   h1b  = m1_bvalid  && m1_bready;
        d0 = m0_rdata; d1 = m1_rdata; rr0 = m0_rresp; rr1 = m1_rresp; br0 = m0_bresp; br1 = m1_bresp;
        if ((m0_outs[40:36] != 5'b0) && (m1_outs[40:36] != 5'b0)) both_active++;
        @(posedge aclk);
        #1;
        if (h0ar) m0_arvalid = 1'b0;
        if (h1ar) m1_arvalid = 1'b0;
        if (h0aw) m0_awvalid = 1'b0;
        if (h1aw) m1_awvalid = 1'b0;
        if (h0w)  m0_wvalid  = 1'b0;
        if (h1w)  m1_wvalid  = 1'b0;
        if (h0r) begin rcap_data[0] = d0; rcap_resp[0] = rr0; done_q.push_back(0); end
        if (h1r) begin rcap_data[1] = d1; rcap_resp[1] = rr1; done_q.push_back(1); end
        if (h0b) begin bcap_resp[0] = br0; done_q.push_back(2); end
        if (h1b) begin bcap_resp[1] = br1; done_q.push_back(3); end
    endtask

    task automatic wait_done(input int n, input int budget, input string tag);
        int k = 0;
        while (done_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(tag, done_q.size(), n);
    endtask

    task automatic clear_masters();
        m0_arvalid = 0; m0_awvalid = 0; m0_wvalid = 0;
        m1_arvalid = 0; m1_awvalid = 0; m1_wvalid = 0;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        clear_masters();
        repeat (2) tick();
        areset = 1'b0;
    endtask

    initial begin
        areset = 1'b1;
        clear_masters();
        m0_araddr = '0; m1_araddr = '0; m0_awaddr = '0; m1_awaddr = '0;
        m0_wdata = '0; m1_wdata = '0; m0_wstrb = '0; m1_wstrb = '0;
        m0_rready = 1; m1_rready = 1; m0_bready = 1; m1_bready = 1;
        slv_rdata_val = 32'h1234_5678; slv_rresp_val = 2'b00; slv_bresp_val = 2'b00;
        repeat (2) tick();
        check("rst_grant", grant, 0);
        check("rst_s_valids", {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready}, 0);
        check("rst_m0_outs", m0_outs, 0);
        check("rst_m1_outs", m1_outs, 0);
        areset = 1'b0;

        // m0 lone read
        m0_araddr = 32'h8000_0000; m0_arvalid = 1;
        tick();
        check("t1_grant", grant, 0);
        check("t1_s_arvalid", s_arvalid, 1);
        check("t1_s_araddr", s_araddr, 32'h8000_0000);
        check("t1_m1_quiet", m1_outs, 0);
        wait_done(1, 10, "t1_done");
        check("t1_code", qget(0), 0);
        check("t1_rdata", rcap_data[0], 32'h1234_5678);
        check("t1_rresp", rcap_resp[0], 0);

        // simultaneous reads after reset: m0 then m1
        do_reset();
        done_q.delete();
        m0_araddr = 32'h100; m1_araddr = 32'h200; m0_arvalid = 1; m1_arvalid = 1;
        wait_done(2, 30, "t2a_done");
        check("t2a_first", qget(0), 0);
        check("t2a_second", qget(1), 1);
        done_q.delete();
        m0_arvalid = 1;
        wait_done(1, 10, "t2b_done");
        check("t2b_m0_alone", qget(0), 0);
        // last is now m0, so the tie goes to m1
        done_q.delete();
        m0_arvalid = 1; m1_arvalid = 1;
        wait_done(2, 30, "t2c_done");
        check("t2c_first", qget(0), 1);
        check("t2c_second", qget(1), 0);

        // m1 write with W late; m0 read stalled until B
        done_q.delete();
        s_aw0 = n_aw; s_w0 = n_w;
        m1_awaddr = 32'h40; m1_wdata = 32'hDEAD_BEEF; m1_wstrb = 8'h0F; m1_awvalid = 1;
        tick();
        check("t3_grant", grant, 1);
        m0_araddr = 32'h300; m0_arvalid = 1;
        repeat (3) begin
            tick();
            check("t3_m0_stall", {m0_arready, s_arvalid}, 0);
        end
        m1_wvalid = 1;
        wait_done(2, 30, "t3_done");
        check("t3_first_b1", qget(0), 3);
        check("t3_then_r0", qget(1), 0);
        check("t3_aw_count", n_aw - s_aw0, 1);
        check("t3_w_count", n_w - s_w0, 1);
        check("t3_wdata", cap_wdata, 32'hDEAD_BEEF);
        check("t3_wstrb", cap_wstrb, 8'h0F);
        check("t3_awaddr", cap_awaddr, 32'h40);
        check("t3_bresp", bcap_resp[1], 0);

        // m0 read stalled on rready while m1 write waits
        done_q.delete();
        m0_rready = 0; m0_araddr = 32'h500; m0_arvalid = 1;
        tick();
        check("t4_grant0", grant, 0);
        m1_awaddr = 32'h60; m1_wdata = 32'h0BAD_F00D; m1_wstrb = 8'hFF;
        m1_awvalid = 1; m1_wvalid = 1;
        repeat (5) begin
            tick();
            check("t4_m1_wait", {m1_awready, m1_wready, s_awvalid, s_wvalid}, 0);
        end
        check("t4_no_done", done_q.size(), 0);
        m0_rready = 1;
        wait_done(1, 5, "t4_r_done");
        check("t4_code", qget(0), 0);
        check("t4_idle_grant", grant, 0);
        check("t4_idle_quiet", {m1_awready, m1_wready, s_awvalid, s_wvalid}, 0);
        tick();
        check("t4_grant1", grant, 1);
        wait_done(2, 20, "t4_b_done");
        check("t4_b_code", qget(1), 3);

        // m1 read and write together, error responses forwarded
        done_q.delete();
        slv_rdata_val = 32'hCAFE_F00D; slv_rresp_val = 2'b10; slv_bresp_val = 2'b11;
        s_ar0 = n_ar; s_aw0 = n_aw; s_w0 = n_w;
        m1_araddr = 32'h700; m1_awaddr = 32'h704; m1_wdata = 32'h1122_3344; m1_wstrb = 8'h03;
        m1_arvalid = 1; m1_awvalid = 1; m1_wvalid = 1;
        wait_done(2, 40, "t5_done");
        check("t5_read_first", qget(0), 1);
        check("t5_write_next", qget(1), 3);
        check("t5_rdata", rcap_data[1], 32'hCAFE_F00D);
        check("t5_rresp", rcap_resp[1], 2'b10);
        check("t5_bresp", bcap_resp[1], 2'b11);
        check("t5_hs_counts", {8'(n_ar - s_ar0), 8'(n_aw - s_aw0), 8'(n_w - s_w0)}, 24'h010101);
        check("t5_wdata", cap_wdata, 32'h1122_3344);

        // reset while WRITE waits on B
        done_q.delete();
        slv_bresp_val = 2'b00; slv_rresp_val = 2'b00;
        m1_bready = 0; m1_awaddr = 32'h800; m1_wdata = 32'h7777_8888; m1_wstrb = 8'hF0;
        m1_awvalid = 1; m1_wvalid = 1;
        repeat (4) tick();
        check("t6_in_write", {grant, m1_bvalid}, 2'b11);
        areset = 1'b1;
        clear_masters();
        tick();
        check("t6_rst_grant", grant, 0);
        check("t6_rst_m0", m0_outs, 0);
        check("t6_rst_m1", m1_outs, 0);
        check("t6_rst_s", {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready}, 0);
        areset = 1'b0;
        m1_bready = 1;
        done_q.delete();
        slv_rdata_val = 32'h55AA_55AA;
        m0_araddr = 32'h900; m0_arvalid = 1;
        wait_done(1, 10, "t6_read_done");
        check("t6_code", qget(0), 0);
        check("t6_rdata", rcap_data[0], 32'h55AA_55AA);

        check("never_both_active", both_active, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_arbiter.md
AXI_ARBITER -- requirements
Module: axi_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, data width; wstrb is fixed at 8 bits.
REQ-003 The block SHALL have port aclk, input, 1, the single clock.
REQ-004 The block SHALL have port areset, input, 1; reset is synchronous and active-high.
REQ-005 The block SHALL have ports mN_araddr/arvalid, input, ADDR_W/1, for N=0,1: master read address.
REQ-006 The block SHALL have ports mN_arready, output, 1: master read-address ready.
REQ-007 The block SHALL have ports mN_rdata/rresp/rvalid, output, DATA_W/2/1: master read data.
REQ-008 The block SHALL have ports mN_rready, input, 1: master read-data ready.
REQ-009 The block SHALL have ports mN_awaddr/awvalid, input, ADDR_W/1: master write address.
REQ-010 The block SHALL have ports mN_wdata/wstrb/wvalid, input, DATA_W/8/1: master write data.
REQ-011 The block SHALL have ports mN_bready, input, 1, and mN_awready/wready/bvalid/bresp, output, 1/1/1/2: master write handshake and response.
REQ-012 The block SHALL have ports s_*, a mirror set of all of the above channels toward the single SRAM slave, with directions reversed.
REQ-013 The block SHALL have port grant, output, 1: the current owner (0 = m0/IFU, 1 = m1/LSU), for debug.

Function
REQ-014 The state machine SHALL have states IDLE, READ, WRITE; one whole transaction at a time is owned by one master.
REQ-015 In IDLE: reqN = mN_arvalid | mN_awvalid | mN_wvalid.
- Winner is chosen round-robin against register last.
- A sole requester always wins.
- The grant is registered and takes effect next cycle, so forwarding starts one cycle after the request is seen.
REQ-016 Within the winning master, a pending read SHALL take precedence over a pending write (next state READ); otherwise next state is WRITE.
REQ-017 In READ, the owner's AR and R channels SHALL pass combinationally to/from s_*.
- READ ends on s_rvalid && s_rready; next state is IDLE and last <= owner.
REQ-018 In WRITE, the owner's AW, W and B channels SHALL pass combinationally and independently; AW before, after or together with W is legal.
- WRITE ends only on s_bvalid && s_bready.
REQ-019 The non-owner SHALL see all readys and r/bvalid at 0. In IDLE, both masters see all outputs at 0 and all s_* valids are 0.
REQ-020 A forwarded ar/aw/w handshake SHALL occur at most once per transaction.
- After s_arvalid&&s_arready, s_arvalid SHALL be held at 0 until the state leaves READ.
- The same applies to AW and W within WRITE (tracked by aw_done/w_done flags).
REQ-021 Requests arriving during a transaction SHALL wait; no valid is dropped, since the master holds it per AXI rules.
REQ-022 An R or B response with non-zero resp SHALL still end the transaction and be forwarded unchanged.
REQ-023 Back-to-back grants SHALL have a minimum of one IDLE cycle between transactions.

Reset
REQ-024 On areset: state=IDLE, last=1 (so m0 wins the first tie), grant=0, aw_done=w_done=0, and all valid/ready outputs are 0.
REQ-025 A reset mid-transaction SHALL abandon it immediately; the slave is reset by the same areset.

Structure
REQ-026 A shared package axi_pkg SHALL hold the arb state enum, the OKAY=2'b00 response constant, and the wstrb width constant.
REQ-027 Two-way round-robin selection SHALL be a sub-module rr_arb2 (req[1:0], last, gnt); everything else is flat.
REQ-028 Target size is 150-300 lines of RTL.

Verification
REQ-029 m0 alone reads 0x80000000 while the slave returns 0x12345678 -> m0_rdata=0x12345678, m0_rresp=0; m1 sees no valids; grant=0.
REQ-030 m0 and m1 both assert arvalid in the same cycle after reset -> m0 is served first, then m1; two simultaneous requests again -> m1 is served before m0 (alternation).
REQ-031 m1 writes 0xDEADBEEF, wstrb 0x0F, with W arriving 3 cycles after AW -> exactly one s_aw and one s_w handshake; m1_bvalid; m0 is stalled until B.
REQ-032 m0 holds rready=0 for 5 cycles during READ while m1 requests a write -> the m1 write does not start until m0 R completes; then one IDLE cycle passes before grant=1.
REQ-033 m1 asserts arvalid and awvalid together -> the read completes first, then the write; no lost handshake.
REQ-034 areset is asserted during WRITE before B -> the next cycle is IDLE, all outputs are 0, and a fresh m0 read completes normally.
